// File: rtl/pdec_pkg.sv
// Shared constants and types for the list polar decoder datapath.
package pdec_pkg;
  localparam int         PDEC_L  = 8;
  localparam int         WID_IDX = 5;
  localparam logic [2:0] JT_REP  = 3'd1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } rd_state_e;
endpackage

// File: rtl/pdec_uph_row_upd.sv
// One path-memory row update: select the parent row, then insert the
// candidate bit(s) at the current bit pointer with an out-of-range check.
module pdec_uph_row_upd
  import pdec_pkg::PDEC_L;
#(
  parameter int WID_N   = 9,
  parameter int WID_IDX = 5
) (
  input  logic [PDEC_L-1:0][(1<<WID_N)-1:0] rows_i,
  input  logic [WID_IDX-1:0]                idx_i,
  input  logic                              rep_i,
  input  logic [WID_N:0]                    ptr_i,
  output logic [(1<<WID_N)-1:0]             row_o,
  output logic                              ovf_hit_o
);
  localparam int             N     = 1 << WID_N;
  localparam logic [WID_N:0] N_PTR = (WID_N+1)'(N);

  logic [2:0]     parent;
  logic [WID_N:0] ptr1;

  always_comb begin
    parent    = rep_i ? idx_i[3:1] : idx_i[4:2];
    ptr1      = ptr_i + {{WID_N{1'b0}}, 1'b1};
    row_o     = rows_i[parent];
    ovf_hit_o = 1'b0;
    if (ptr_i < N_PTR) row_o[ptr_i[WID_N-1:0]] = idx_i[0];
    else               ovf_hit_o = 1'b1;
    // Info nodes carry a second bit at ptr+1.
    if (!rep_i) begin
      if (ptr1 < N_PTR) row_o[ptr1[WID_N-1:0]] = idx_i[1];
      else              ovf_hit_o = 1'b1;
    end
  end
endmodule

// File: rtl/pdec_updt_path.sv
// Path-memory update stage: permutes/extends the 8 decoded-bit histories on each
// sorter result and streams the best path out as bytes once decoding finishes.
module pdec_updt_path
  import pdec_pkg::PDEC_L, pdec_pkg::JT_REP, pdec_pkg::rd_state_e,
         pdec_pkg::ST_IDLE, pdec_pkg::ST_RD;
#(
  parameter int WID_N   = 9,
  parameter int WID_IDX = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      pdec_clk_en5,
  input  logic [2:0]                cur_jump_type,
  input  logic                      ctrl2uph_init,
  input  logic                      ctrl2uph_rd_st,
  input  logic                      srt2uph_idx_vld,
  input  logic [WID_IDX*PDEC_L-1:0] srt2uph_pm_idx,
  output logic                      uph2ctrl_updt_done,
  output logic                      uph2ctrl_ovf,
  output logic [7:0]                uph2out_dat,
  output logic                      uph2out_vld,
  output logic                      uph2out_last
);
  localparam int               N       = 1 << WID_N;
  localparam int               NB      = N / 8;
  localparam logic [WID_N:0]   N_PTR   = (WID_N+1)'(N);
  localparam logic [WID_N-3:0] RD_LAST = (WID_N-2)'(NB - 1);

  logic [PDEC_L-1:0][N-1:0] mem_q;
  logic [PDEC_L-1:0][N-1:0] mem_d;
  logic [PDEC_L-1:0]        hit;
  logic [WID_N:0]           bit_ptr_q, bit_ptr_d, ptr_step, ptr_sum;
  logic                     ovf_q, updt_done_q;
  logic                     rep_mode, upd_en;

  rd_state_e                state_q, state_d;
  logic [WID_N-3:0]         rd_cnt_q, rd_cnt_d;
  logic [WID_N-1:0]         rd_base;
  logic [7:0]               dat_q, dat_d;
  logic                     vld_q, vld_d, last_q, last_d;

  assign rep_mode = (cur_jump_type == JT_REP);
  assign upd_en   = srt2uph_idx_vld & ~ctrl2uph_init;

  for (genvar i = 0; i < PDEC_L; i++) begin : g_row
    pdec_uph_row_upd #(
      .WID_N   (WID_N),
      .WID_IDX (WID_IDX)
    ) u_row (
      .rows_i    (mem_q),
      .idx_i     (srt2uph_pm_idx[WID_IDX*i +: WID_IDX]),
      .rep_i     (rep_mode),
      .ptr_i     (bit_ptr_q),
      .row_o     (mem_d[i]),
      .ovf_hit_o (hit[i])
    );
  end

  always_comb begin
    ptr_step  = rep_mode ? {{WID_N{1'b0}}, 1'b1} : {{(WID_N-1){1'b0}}, 2'b10};
    ptr_sum   = bit_ptr_q + ptr_step;
    bit_ptr_d = (ptr_sum > N_PTR) ? N_PTR : ptr_sum;
  end

  // All rows are written together from pre-update contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q       <= '0;
      bit_ptr_q   <= '0;
      ovf_q       <= 1'b0;
      updt_done_q <= 1'b0;
    end else begin
      updt_done_q <= upd_en;
      if (ctrl2uph_init) begin
        mem_q     <= '0;
        bit_ptr_q <= '0;
        ovf_q     <= 1'b0;
      end else if (upd_en) begin
        mem_q     <= mem_d;
        bit_ptr_q <= bit_ptr_d;
        ovf_q     <= ovf_q | (|hit);
      end
    end
  end

  // Output registers are loaded from the next state so data aligns with rd_cnt.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    if (ctrl2uph_init) begin
      state_d  = ST_IDLE;
      rd_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (ctrl2uph_rd_st) begin
          state_d  = ST_RD;
          rd_cnt_d = '0;
        end
        ST_RD: if (rd_cnt_q == RD_LAST) begin
          state_d  = ST_IDLE;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + (WID_N-2)'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
    vld_d   = (state_d == ST_RD);
    rd_base = {rd_cnt_d[WID_N-4:0], 3'b000};
    dat_d   = vld_d ? mem_q[0][rd_base +: 8] : 8'h00;
    last_d  = vld_d && (rd_cnt_d == RD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rd_cnt_q <= '0;
      dat_q    <= '0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      dat_q    <= dat_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
    end
  end

  assign pdec_clk_en5 = ctrl2uph_init | ctrl2uph_rd_st | srt2uph_idx_vld |
                        updt_done_q | (state_q == ST_RD);

  assign uph2ctrl_updt_done = updt_done_q;
  assign uph2ctrl_ovf       = ovf_q;
  assign uph2out_dat        = dat_q;
  assign uph2out_vld        = vld_q;
  assign uph2out_last       = last_q;
endmodule

// File: tb/tb_pdec_updt_path.sv
// Randomized bench for pdec_updt_path against an array-based model of the path memory.
module tb_pdec_updt_path;
  localparam int WID_N = 9;
  localparam int N     = 512;
  localparam int NB    = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic [2:0]  jt;
  logic        init, rd_st, idx_vld;
  logic [39:0] idx;
  logic        updt_done, ovf, vld, last;
  logic [7:0]  dat;

  always #5 clk = ~clk;

  pdec_updt_path #(.WID_N(WID_N), .WID_IDX(5)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pdec_clk_en5       (clk_en),
    .cur_jump_type      (jt),
    .ctrl2uph_init      (init),
    .ctrl2uph_rd_st     (rd_st),
    .srt2uph_idx_vld    (idx_vld),
    .srt2uph_pm_idx     (idx),
    .uph2ctrl_updt_done (updt_done),
    .uph2ctrl_ovf       (ovf),
    .uph2out_dat        (dat),
    .uph2out_vld        (vld),
    .uph2out_last       (last)
  );

  logic [N-1:0] m [8];
  int           mptr;
  logic         movf;
  int           errors = 0;
  int           checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    for (int r = 0; r < 8; r++) m[r] = '0;
    mptr = 0;
    movf = 1'b0;
  endtask

  task automatic model_update(input logic [2:0] t, input logic [39:0] ix);
    logic [N-1:0] old [8];
    logic [4:0]   v;
    int           par, nb, pos;
    for (int r = 0; r < 8; r++) old[r] = m[r];
    nb = (t == 3'd1) ? 1 : 2;
    for (int i = 0; i < 8; i++) begin
      v    = ix[5*i +: 5];
      par  = (nb == 1) ? int'(v[3:1]) : int'(v[4:2]);
      m[i] = old[par];
      for (int j = 0; j < nb; j++) begin
        pos = mptr + j;
        if (pos < N) m[i][pos] = v[j];
        else         movf = 1'b1;
      end
    end
    mptr = (mptr + nb > N) ? N : mptr + nb;
  endtask

  function automatic logic [39:0] rand_idx();
    logic [39:0] r;
    r[31:0]  = $urandom;
    r[39:32] = 8'($urandom);
    return r;
  endfunction

  task automatic pulse_init();
    init = 1'b1;
    tick();
    init = 1'b0;
    model_init();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({updt_done, ovf, dat, vld, last, clk_en} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {updt_done, ovf, dat, vld, last, clk_en});
    end
    checks++;
    if (dut.bit_ptr_q !== 10'd0 || dut.mem_q !== '0) begin
      errors++;
      $display("FAIL reset_state: ptr got %0d expected 0", dut.bit_ptr_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({updt_done, ovf, dat, vld, last, clk_en} !== 13'd0) begin
      errors++;
      $display("FAIL idle_outputs: got %h expected 0", {updt_done, ovf, dat, vld, last, clk_en});
    end
    model_init();
  endtask

  task automatic test_zero_readout();
    pulse_init();
    rd_st = 1'b1;
    checks++;
    if (clk_en !== 1'b1) begin
      errors++;
      $display("FAIL clk_en_rdst: got %b expected 1", clk_en);
    end
    tick();
    rd_st = 1'b0;
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (vld !== 1'b1 || dat !== 8'h00 || last !== (k == NB - 1)) begin
        errors++;
        $display("FAIL zero_rd byte%0d: got vld=%b dat=%h last=%b expected vld=1 dat=00 last=%b",
                 k, vld, dat, last, (k == NB - 1));
      end
      if (k < NB - 1) tick();
    end
    tick();
    checks++;
    if ({vld, last, dat, clk_en} !== 11'd0) begin
      errors++;
      $display("FAIL zero_rd_end: got %h expected 0", {vld, last, dat, clk_en});
    end
  endtask

  task automatic test_rep();
    pulse_init();
    jt = 3'd1;
    for (int i = 0; i < 8; i++) idx[5*i +: 5] = 5'(2*i + 1);
    idx_vld = 1'b1;
    model_update(jt, idx);
    tick();
    idx_vld = 1'b0;
    checks++;
    if (updt_done !== 1'b1) begin
      errors++;
      $display("FAIL rep_done: got %b expected 1", updt_done);
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (dut.mem_q[r][0] !== 1'b1 || dut.mem_q[r] !== m[r]) begin
        errors++;
        $display("FAIL rep_row%0d: got %h expected %h", r, dut.mem_q[r], m[r]);
      end
    end
    checks++;
    if (dut.bit_ptr_q !== 10'd1) begin
      errors++;
      $display("FAIL rep_ptr: got %0d expected 1", dut.bit_ptr_q);
    end
    tick();
    checks++;
    if (updt_done !== 1'b0) begin
      errors++;
      $display("FAIL rep_done_pulse: got %b expected 0", updt_done);
    end
  endtask

  task automatic test_info_perm();
    pulse_init();
    jt      = 3'd0;
    idx     = 40'd0;
    idx[29:25] = 5'd20;
    idx_vld = 1'b1;
    model_update(jt, idx);
    tick();
    idx     = 40'd0;
    idx[4:0] = 5'd22;
    model_update(jt, idx);
    tick();
    idx_vld = 1'b0;
    checks++;
    if (dut.mem_q[0][3:0] !== 4'b1000) begin
      errors++;
      $display("FAIL perm_row0: got %b expected 1000", dut.mem_q[0][3:0]);
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (dut.mem_q[r] !== m[r]) begin
        errors++;
        $display("FAIL perm_row%0d: got %h expected %h", r, dut.mem_q[r], m[r]);
      end
    end
    checks++;
    if (dut.bit_ptr_q !== 10'd4) begin
      errors++;
      $display("FAIL perm_ptr: got %0d expected 4", dut.bit_ptr_q);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    pulse_init();
    for (int c = 0; c < 40; c++) begin
      idx_vld  = ($urandom_range(3) != 0);
      jt       = 3'($urandom_range(7));
      idx      = rand_idx();
      exp_done = idx_vld;
      if (idx_vld) model_update(jt, idx);
      tick();
      checks++;
      if (updt_done !== exp_done) begin
        errors++;
        $display("FAIL b2b_done c%0d: got %b expected %b", c, updt_done, exp_done);
      end
      for (int r = 0; r < 8; r++) begin
        checks++;
        if (dut.mem_q[r] !== m[r]) begin
          errors++;
          $display("FAIL b2b_row%0d c%0d: got %h expected %h", r, c, dut.mem_q[r], m[r]);
        end
      end
      checks++;
      if (dut.bit_ptr_q !== 10'(mptr) || ovf !== movf) begin
        errors++;
        $display("FAIL b2b_ptr c%0d: got %0d/%b expected %0d/%b", c, dut.bit_ptr_q, ovf, mptr, movf);
      end
    end
    idx_vld = 1'b0;
    tick();
    rd_st = 1'b1;
    tick();
    rd_st = 1'b0;
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (vld !== 1'b1 || dat !== m[0][8*k +: 8] || last !== (k == NB - 1)) begin
        errors++;
        $display("FAIL b2b_rd byte%0d: got vld=%b dat=%h last=%b expected dat=%h", k, vld, dat, last, m[0][8*k +: 8]);
      end
      tick();
    end
    checks++;
    if (vld !== 1'b0 || dat !== 8'h00) begin
      errors++;
      $display("FAIL b2b_rd_end: got vld=%b dat=%h expected 0/00", vld, dat);
    end
  endtask

  task automatic test_overflow();
    logic [N-1:0] snap [8];
    pulse_init();
    jt      = 3'd0;
    idx_vld = 1'b1;
    for (int c = 0; c < N/2; c++) begin
      idx = rand_idx();
      model_update(jt, idx);
      tick();
    end
    idx_vld = 1'b0;
    tick();
    checks++;
    if (ovf !== 1'b0 || dut.bit_ptr_q !== 10'd512) begin
      errors++;
      $display("FAIL ovf_full: got ovf=%b ptr=%0d expected 0/512", ovf, dut.bit_ptr_q);
    end
    for (int r = 0; r < 8; r++) begin
      snap[r] = m[r];
      checks++;
      if (dut.mem_q[r] !== m[r]) begin
        errors++;
        $display("FAIL ovf_full_row%0d: got %h expected %h", r, dut.mem_q[r], m[r]);
      end
    end
    for (int i = 0; i < 8; i++) idx[5*i +: 5] = {3'(i), 2'b11};
    idx_vld = 1'b1;
    model_update(jt, idx);
    tick();
    idx_vld = 1'b0;
    tick();
    checks++;
    if (ovf !== 1'b1 || ovf !== movf) begin
      errors++;
      $display("FAIL ovf_set: got %b expected 1", ovf);
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (dut.mem_q[r] !== snap[r] || dut.mem_q[r] !== m[r]) begin
        errors++;
        $display("FAIL ovf_row%0d: got %h expected %h", r, dut.mem_q[r], snap[r]);
      end
    end
  endtask

  task automatic test_init_collision();
    jt      = 3'd1;
    idx     = rand_idx();
    idx_vld = 1'b1;
    init    = 1'b1;
    model_init();
    tick();
    idx_vld = 1'b0;
    init    = 1'b0;
    checks++;
    if (updt_done !== 1'b0) begin
      errors++;
      $display("FAIL coll_done: got %b expected 0", updt_done);
    end
    checks++;
    if (dut.mem_q !== '0 || dut.bit_ptr_q !== 10'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL coll_state: got ptr=%0d ovf=%b expected 0/0", dut.bit_ptr_q, ovf);
    end
    tick();
  endtask

  task automatic test_init_mid_readout();
    pulse_init();
    jt      = 3'd0;
    idx_vld = 1'b1;
    for (int c = 0; c < 80; c++) begin
      idx = rand_idx();
      model_update(jt, idx);
      tick();
    end
    idx_vld = 1'b0;
    rd_st   = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (vld !== 1'b1 || dat !== m[0][8*k +: 8] || last !== 1'b0) begin
        errors++;
        $display("FAIL mid_rd byte%0d: got vld=%b dat=%h expected dat=%h", k, vld, dat, m[0][8*k +: 8]);
      end
      rd_st = (k == 5);
      tick();
    end
    rd_st = 1'b0;
    init  = 1'b1;
    tick();
    init  = 1'b0;
    model_init();
    checks++;
    if (vld !== 1'b0 || dat !== 8'h00 || last !== 1'b0) begin
      errors++;
      $display("FAIL mid_init: got vld=%b dat=%h last=%b expected 0", vld, dat, last);
    end
    tick();
    checks++;
    if (vld !== 1'b0 || dut.bit_ptr_q !== 10'd0) begin
      errors++;
      $display("FAIL mid_init_hold: got vld=%b ptr=%0d expected 0/0", vld, dut.bit_ptr_q);
    end
  endtask

  task automatic test_async_reset();
    jt      = 3'd1;
    idx     = 40'hFF_FFFF_FFFF;
    idx_vld = 1'b1;
    tick();
    idx_vld = 1'b0;
    rd_st   = 1'b1;
    tick();
    rd_st   = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({updt_done, ovf, dat, vld, last, clk_en} !== 13'd0) begin
      errors++;
      $display("FAIL async_rst_out: got %h expected 0", {updt_done, ovf, dat, vld, last, clk_en});
    end
    checks++;
    if (dut.mem_q !== '0 || dut.bit_ptr_q !== 10'd0) begin
      errors++;
      $display("FAIL async_rst_state: got ptr=%0d expected 0", dut.bit_ptr_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    jt      = 3'd0;
    init    = 1'b0;
    rd_st   = 1'b0;
    idx_vld = 1'b0;
    idx     = 40'd0;
    model_init();
    test_reset();
    test_zero_readout();
    test_rep();
    test_info_perm();
    test_back_to_back();
    test_overflow();
    test_init_collision();
    test_init_mid_readout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pdec_updt_path.md
# pdec_updt_path

Path-memory update stage of the list polar decoder, directly downstream of the PM sorter. For each sorter result it copies each surviving path's decoded-bit history from its parent path and appends the candidate bits. The copy is driven by the 8 sorted indices `srt2uph_pm_idx`, where idx0 is the best path. After the codeword is complete it streams the best path's (path 0) decoded bits out as bytes.

## Interface
Parameters:
- `WID_N`, 9, log2 of code length N (512 → 9, 4096 → 12); the path memory is 8 rows × N bits.
- `WID_IDX`, 5, sorter index width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `pdec_clk_en5`  out  1  ICG enable for this block.
- `cur_jump_type`  in  3  broadcast; 3'd1 = rep node (1 bit/step), any other value = info node (2 bits/step).
- `ctrl2uph_init`  in  1  single-cycle pulse at codeword start.
- `ctrl2uph_rd_st`  in  1  single-cycle pulse that starts best-path readout.
- `srt2uph_idx_vld`  in  1  sorter done, aligned with `srt2uph_pm_idx`.
- `srt2uph_pm_idx`  in  5*8  {idx7..idx0}.
- `uph2ctrl_updt_done`  out  1  pulse, one per applied update.
- `uph2ctrl_ovf`  out  1  sticky; a bit write targeted a position ≥ N since the last init.
- `uph2out_dat`  out  8  readout byte; bit j = decoded bit 8k+j.
- `uph2out_vld`  out  1  readout byte valid.
- `uph2out_last`  out  1  last byte of the readout.

## Operation
- State: `mem[0..7][N-1:0]`, `bit_ptr[WID_N:0]`, readout FSM {IDLE, RD}, readout counter `rd_cnt[WID_N-3:0]`.
- Init: clears `mem` to 0, `bit_ptr` to 0 and `uph2ctrl_ovf`. It forces the FSM to IDLE, aborting any readout.
- Update on `srt2uph_idx_vld` (when no init is present):
  - Rep mode: parent_i = idx_i[3:1], b = idx_i[0]. idx_i[4] is ignored.
  - Info mode: parent_i = idx_i[4:2], k = idx_i[1:0].
  - All 8 rows read pre-update contents, so the permutation is simultaneous. Example: row 3 may copy row 5 while row 5 copies row 0.
  - new row_i = old mem[parent_i] with inserted bits:
    - Rep: bit[ptr] = b.
    - Info: bit[ptr] = k[0], bit[ptr+1] = k[1].
  - `bit_ptr` += 1 (rep) or 2 (info), saturating at N.
  - Any insert position ≥ N is dropped and sets `uph2ctrl_ovf`.
- Simultaneous `ctrl2uph_init` and `srt2uph_idx_vld`: init wins, the update is discarded, and no `updt_done` is produced.
- Readout FSM:
  - IDLE → RD on `ctrl2uph_rd_st`; `rd_cnt` = 0.
  - In RD, the block outputs byte `mem[0][8*rd_cnt +: 8]` with `uph2out_vld` = 1, one byte per cycle, N/8 bytes total.
  - `uph2out_last` on rd_cnt = N/8−1, then RD → IDLE.
  - `rd_st` while in RD is ignored.
  - Readout reads live `mem`; ctrl never overlaps updates with readout, and the bench does not check the result if it does.
- `pdec_clk_en5` = init | rd_st | idx_vld | `updt_done` | (state == RD).

## Timing
- Reset values:
  - `mem` = 0, `bit_ptr` = 0, FSM = IDLE.
  - All outputs are 0: `updt_done`, `ovf`, `dat`, `vld`, `last`. `pdec_clk_en5` is combinational and is 0 while its inputs are 0.
- Update latency:
  - `idx_vld` sampled at edge t → `mem`/`bit_ptr` written at edge t.
  - `uph2ctrl_updt_done` registered, high in cycle t+1 for exactly one cycle.
  - Back-to-back `idx_vld` every cycle is supported.
- Readout latency:
  - `rd_st` in cycle t → first byte with `vld` in cycle t+1.
  - The last byte is in cycle t+N/8; `dat`/`vld`/`last` are registered outputs.
  - `dat` returns to 0 when `vld` is low.
- Init mid-readout: `vld` is low in the cycle after init.
- Reset mid-operation is asynchronous and returns everything to reset values immediately.

## Structure
- Shared package `pdec_pkg` holds:
  - `PDEC_L` = 8, `WID_IDX` = 5.
  - Jump-type constant `JT_REP` = 3'd1.
- Sub-module `pdec_uph_row_upd`, instantiated 8×: an 8:1 parent-row mux plus 1/2-bit insert at `bit_ptr` with range check, and an `ovf_hit` output.
- The top holds `mem`, `bit_ptr`, the readout FSM and the ICG logic.

## Test plan
- Reset, then idle → all outputs 0; init then `rd_st` with N = 512 → 64 zero bytes, `last` on byte 63 in cycle t+64.
- Rep mode: `idx_vld` with idx_i = 2i+1 (i = 0..7) → every row bit0 = 1, `bit_ptr` = 1, `updt_done` one cycle later.
- Info mode permutation:
  - Preload row 5 with info idx = {5'd20} at ptr 0 → row 5 bits[1:0] = 00.
  - Then idx0 = 5'd22, all other idx = 0 → row 0 bits[3:0] = 4'b1000 (copied from row 5, k = 2).
  - Rows 1–7 become copies of old row 0 plus k = 0.
- Overflow: 256 info updates fill N = 512 → `ovf` = 0; one more update → `ovf` = 1 and `mem` is unchanged.
- Init in the same cycle as `idx_vld` → no `updt_done`, `mem` = 0, `bit_ptr` = 0.
- Init in the middle of a readout → `vld` drops the next cycle; a second `rd_st` sent during RD is ignored.
